// File: rtl/phy_tx.sv
// phy_tx: USB 2.0 full-speed transmit PHY.
// Takes bytes from the SIE and drives the bus in this order: SYNC, then NRZI-encoded,
// bit-stuffed data sent LSB first, then EOP (SE0, SE0, J).
//
// Ports:
//   clk_i       clock, 12 MHz * BIT_SAMPLES
//   rst_i       asynchronous, active-high reset
//   tx_valid_i  SIE has a byte on tx_data_i; low at a byte-load point ends the packet
//   tx_data_i   byte to send, LSB first
//   tx_ready_o  one-clock pulse when tx_data_i has been consumed
//   tx_en_o     bus driver enable, high from the first SYNC bit to the end of the EOP J
//   dp_tx_o     dp line level
//   dn_tx_o     dn line level
module phy_tx #(
  parameter int unsigned BIT_SAMPLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tx_valid_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_ready_o,
  output logic       tx_en_o,
  output logic       dp_tx_o,
  output logic       dn_tx_o
);

  localparam int unsigned CW = (BIT_SAMPLES > 1) ? $clog2(BIT_SAMPLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BIT_SAMPLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    DATA,
    EOP
  } state_t;

  state_t        state;
  logic [CW-1:0] clk_cnt;
  // SYNC: symbol index; DATA: data bits still to send; EOP: symbol index.
  logic [3:0]    bit_cnt;
  logic [2:0]    ones;
  logic [7:0]    shreg;
  logic          bit_end;
  logic          cur_bit;

  assign bit_end = (clk_cnt == CNT_MAX);

  // Next data bit: the shifter mid-byte, otherwise bit 0 of the byte being loaded.
  always_comb begin
    cur_bit = tx_data_i[0];
    if (state == DATA && bit_cnt != '0) begin
      cur_bit = shreg[0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      ones       <= '0;
      shreg      <= '0;
      tx_ready_o <= 1'b0;
      tx_en_o    <= 1'b0;
      dp_tx_o    <= 1'b1;
      dn_tx_o    <= 1'b0;
    end else begin
      tx_ready_o <= 1'b0;

      if (state == IDLE || bit_end) begin
        clk_cnt <= '0;
      end else begin
        clk_cnt <= clk_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (tx_valid_i) begin
            state   <= SYNC;
            bit_cnt <= '0;
            // The final SYNC K counts as the first one for stuffing purposes.
            ones    <= 3'd1;
            tx_en_o <= 1'b1;
            dp_tx_o <= 1'b0;
            dn_tx_o <= 1'b1;
          end
        end

        SYNC, DATA: begin
          if (bit_end) begin
            if (state == SYNC && bit_cnt != 4'd7) begin
              // KJKJKJKK: every symbol toggles except the last, which holds.
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt != 4'd6) begin
                dp_tx_o <= ~dp_tx_o;
                dn_tx_o <= ~dn_tx_o;
              end
            end else if (state == DATA && ones == 3'd6) begin
              // Stuffed zero; the shifter holds, and a stuff owed after bit 7
              // is sent here before the byte-load decision below.
              ones    <= '0;
              dp_tx_o <= ~dp_tx_o;
              dn_tx_o <= ~dn_tx_o;
            end else if ((state == DATA && bit_cnt != '0) || tx_valid_i) begin
              if (state == DATA && bit_cnt != '0) begin
                shreg   <= {1'b0, shreg[7:1]};
                bit_cnt <= bit_cnt - 4'd1;
              end else begin
                shreg      <= {1'b0, tx_data_i[7:1]};
                bit_cnt    <= 4'd7;
                tx_ready_o <= 1'b1;
                state      <= DATA;
              end
              if (cur_bit) begin
                ones <= ones + 3'd1;
              end else begin
                ones    <= '0;
                dp_tx_o <= ~dp_tx_o;
                dn_tx_o <= ~dn_tx_o;
              end
            end else begin
              state   <= EOP;
              bit_cnt <= '0;
              dp_tx_o <= 1'b0;
              dn_tx_o <= 1'b0;
            end
          end
        end

        EOP: begin
          if (bit_end) begin
            case (bit_cnt)
              4'd0: bit_cnt <= 4'd1;
              4'd1: begin
                bit_cnt <= 4'd2;
                dp_tx_o <= 1'b1;
                dn_tx_o <= 1'b0;
              end
              default: begin
                bit_cnt <= '0;
                tx_en_o <= 1'b0;
                state   <= IDLE;
              end
            endcase
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phy_tx.sv
// tb_phy_tx: table-driven bench for phy_tx with BIT_SAMPLES=4.
// Line symbols are sampled mid-bit and collected as a string: J, K, 0 (SE0).
module tb_phy_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_en;
  logic       dp;
  logic       dn;

  always #5 clk = ~clk;

  phy_tx #(.BIT_SAMPLES(4)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .tx_valid_i (tx_valid),
    .tx_data_i  (tx_data),
    .tx_ready_o (tx_ready),
    .tx_en_o    (tx_en),
    .dp_tx_o    (dp),
    .dn_tx_o    (dn)
  );

  int checks   = 0;
  int failures = 0;

  // Monitor state (written only by the monitor; the driver snapshots it).
  int    cyc       = 0;
  int    en_clks   = 0;
  string line_s    = "";
  int    ready_q[$];
  int    eop_q[$];
  logic  prev_se0  = 1'b0;

  function automatic string sym(logic p, logic n);
    if (p && !n) return "J";
    if (!p && n) return "K";
    if (!p && !n) return "0";
    return "X";
  endfunction

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (tx_ready) ready_q.push_back(cyc);
    if (tx_en) begin
      en_clks = en_clks + 1;
      if (en_clks % 4 == 3) line_s = {line_s, sym(dp, dn)};
      if (!dp && !dn && !prev_se0) eop_q.push_back(cyc);
    end
    prev_se0 = tx_en && !dp && !dn;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_s(input string name, input string act, input string exp);
    checks = checks + 1;
    if (act != exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %s expected %s", name, act, exp);
    end
  endtask

  typedef struct {
    string           name;
    int              nbytes;
    logic [2:0][7:0] d;
    string           exp_line;
    int              exp_ready;
    int              exp_en;
    int              exp_gap;   // clocks from last tx_ready to first SE0
  } vec_t;

  task automatic run_vec(input vec_t v);
    int r0, e0, l0, q0, k, guard;
    string got;
    r0 = ready_q.size();
    e0 = en_clks;
    l0 = line_s.len();
    q0 = eop_q.size();
    k  = 0;
    @(posedge clk); #1;
    tx_data  = v.d[0];
    tx_valid = 1'b1;
    @(posedge clk); #1;
    chk({v.name, " first_K"}, {tx_en, dp, dn}, 3'b101);
    if (v.nbytes == 0) tx_valid = 1'b0;
    guard = 0;
    while (tx_en && guard < 1000) begin
      if (tx_ready) begin
        k = k + 1;
        if (k < v.nbytes) tx_data = v.d[k];
        else tx_valid = 1'b0;
      end
      @(posedge clk); #1;
      guard = guard + 1;
    end
    chk({v.name, " timeout"}, guard < 1000 ? 1 : 0, 1);
    tx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    got = (line_s.len() > l0) ? line_s.substr(l0, line_s.len() - 1) : "";
    chk_s({v.name, " line"}, got, v.exp_line);
    chk({v.name, " en_clks"}, en_clks - e0, v.exp_en);
    chk({v.name, " ready_pulses"}, ready_q.size() - r0, v.exp_ready);
    chk({v.name, " idle_J"}, {tx_en, dp, dn}, 3'b010);
    if (v.nbytes > 0) begin
      if (ready_q.size() >= r0 + v.nbytes && eop_q.size() > q0)
        chk({v.name, " eop_gap"}, eop_q[q0] - ready_q[r0 + v.nbytes - 1], v.exp_gap);
      else
        chk({v.name, " eop_gap_missing"}, 0, 1);
      for (int i = 1; i < v.nbytes; i++) begin
        if (ready_q.size() > r0 + i)
          chk({v.name, " ready_spacing"}, ready_q[r0 + i] - ready_q[r0 + i - 1], 32);
      end
    end
  endtask

  vec_t vecs[$];
  vec_t v;

  initial begin
    int act;
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {dp, dn, tx_en, tx_ready}, 4'b1000);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("post_reset_idle", {dp, dn, tx_en, tx_ready}, 4'b1000);

    vecs.push_back('{"ack",    1, {8'h00, 8'h00, 8'hD2}, "KJKJKJKKJJKJJKKK00J",          1,  76, 32});
    vecs.push_back('{"stuffFF",1, {8'h00, 8'h00, 8'hFF}, "KJKJKJKKKKKKKJJJJ00J",         1,  80, 36});
    vecs.push_back('{"midst3F",1, {8'h00, 8'h00, 8'h3F}, "KJKJKJKKKKKKKJJKJ00J",         1,  80, 36});
    vecs.push_back('{"endstFC",1, {8'h00, 8'h00, 8'hFC}, "KJKJKJKKJKKKKKKKJ00J",         1,  80, 36});
    vecs.push_back('{"stream", 3, {8'h03, 8'h02, 8'h01}, "KJKJKJKKKJKJKJKJKKJKJKJKKKJKJKJK00J", 3, 140, 32});
    vecs.push_back('{"empty",  0, {8'h00, 8'h00, 8'h00}, "KJKJKJKK00J",                  0,  44, 0});

    foreach (vecs[i]) begin
      v = vecs[i];
      run_vec(v);
    end

    // Reset asserted mid-DATA must take effect without a clock edge.
    @(posedge clk); #1;
    tx_data  = 8'hD2;
    tx_valid = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    chk("pre_abort_en", tx_en, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_async", {dp, dn, tx_en, tx_ready}, 4'b1000);
    tx_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    act = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (tx_en || !dp || dn || tx_ready) act = act + 1;
    end
    chk("no_activity_after_abort", act, 0);

    v = vecs[0];
    run_vec(v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
